// File: rtl/lab2_proc_alu_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit ALU. One accepted request per cycle;
// the result and flags sit in a single-entry buffer tagged with its owner until that
// owner's response port takes it.
module lab2_proc_alu_arbiter #(
    parameter int unsigned p_round_robin = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_val,
    output logic        req0_rdy,
    input  logic [67:0] req0_msg,
    output logic        resp0_val,
    input  logic        resp0_rdy,
    output logic [34:0] resp0_msg,
    input  logic        req1_val,
    output logic        req1_rdy,
    input  logic [67:0] req1_msg,
    output logic        resp1_val,
    input  logic        resp1_rdy,
    output logic [34:0] resp1_msg
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [34:0] data_q, data_d;

    logic        space;
    logic        grant;
    logic        req_acc;
    logic        resp_acc;
    logic [67:0] alu_msg;
    logic [3:0]  fn;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [31:0] alu_out;
    logic [31:0] sum;
    logic [4:0]  shamt;
    logic        flag_eq;
    logic        flag_lt;
    logic        flag_ltu;

    // Grant selection and ready generation; rdy never looks at the granted requester's handshake.
    always_comb begin
        resp_acc = owner_q ? resp1_rdy : resp0_rdy;
        space    = (state_q == StEmpty) || resp_acc;
        if (req0_val && req1_val) begin
            // last_q resets to 1, so requester 0 wins the first tie
            grant = (p_round_robin != 0) ? ~last_q : 1'b0;
        end else begin
            grant = req1_val;
        end
        req0_rdy = space & ~grant;
        req1_rdy = space & grant;
        req_acc  = grant ? req1_val : req0_val;
        req_acc  = req_acc & space;
        alu_msg  = grant ? req1_msg : req0_msg;
    end

    // Shared ALU evaluated on the granted request's fields.
    always_comb begin
        fn       = alu_msg[67:64];
        in0      = alu_msg[63:32];
        in1      = alu_msg[31:0];
        shamt    = in1[4:0];
        sum      = in0 + in1;
        flag_eq  = (in0 == in1);
        flag_lt  = ($signed(in0) < $signed(in1));
        flag_ltu = (in0 < in1);
        alu_out  = 32'h0;
        case (fn)
            4'd0:    alu_out = sum;
            4'd1:    alu_out = in0 - in1;
            4'd2:    alu_out = in0 & in1;
            4'd3:    alu_out = in0 | in1;
            4'd4:    alu_out = in0 ^ in1;
            4'd5:    alu_out = {31'h0, flag_lt};
            4'd6:    alu_out = {31'h0, flag_ltu};
            4'd7:    alu_out = $unsigned($signed(in0) >>> shamt);
            4'd8:    alu_out = in0 >> shamt;
            4'd9:    alu_out = in0 << shamt;
            4'd10:   alu_out = sum & 32'hffff_fffe;
            4'd11:   alu_out = in0;
            4'd12:   alu_out = in1;
            default: alu_out = 32'h0;
        endcase
    end

    // Buffer next state: a new accept overwrites (even while draining), otherwise a drain empties.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        if (req_acc) begin
            state_d = StFull;
            owner_d = grant;
            last_d  = grant;
            data_d  = {flag_ltu, flag_lt, flag_eq, alu_out};
        end else if ((state_q == StFull) && resp_acc) begin
            state_d = StEmpty;
        end
    end

    // Response outputs driven straight from the buffer.
    always_comb begin
        resp0_val = (state_q == StFull) && !owner_q;
        resp1_val = (state_q == StFull) && owner_q;
        resp0_msg = data_q;
        resp1_msg = data_q;
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEmpty;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= 35'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: doc/lab2_proc_alu_arbiter.md
# lab2_proc_alu_arbiter

Shares one 32-bit ALU between two independent requesters, e.g. the X-stage and a branch/address unit, over val/rdy interfaces. Each cycle it grants at most one request, using round-robin or fixed priority. It registers the ALU result and comparison flags in a single-entry output buffer tagged with the owning requester, and holds them until that requester's response port accepts.

## Interface
Parameters:
- p_round_robin, default 1: 1 = round-robin grant; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; all state clears immediately while low.
- req0_val  input  1  requester 0 request valid.
- req0_rdy  output  1  requester 0 request accepted when val & rdy.
- req0_msg  input  68  [67:64] fn, [63:32] in0, [31:0] in1.
- resp0_val  output  1  response for requester 0 valid.
- resp0_rdy  input  1  requester 0 can take the response.
- resp0_msg  output  35  [34] ltu, [33] lt, [32] eq, [31:0] out.
- req1_val, req1_rdy, req1_msg, resp1_val, resp1_rdy, resp1_msg: identical to port 0, for requester 1.

## Operation
- ALU function encoding (fn, 4 bits):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT, signed; 6 SLTU.
  - 7 SRA, 8 SRL, 9 SLL; shift amount is in1[4:0].
  - 10 JALR, computes (in0+in1) & 32'hfffffffe.
  - 11 pass in0; 12 pass in1.
  - 13–15 give out = 0.
- Flags, independent of fn:
  - eq = (in0 == in1).
  - lt = signed in0 < in1.
  - ltu = unsigned in0 < in1.
- Arithmetic wraps modulo 2^32; no overflow indication.
- Buffer state machine has two states:
  - EMPTY: resp0_val = resp1_val = 0.
  - FULL(owner): resp<owner>_val = 1; the other resp_val = 0.
- space = EMPTY, or (FULL and resp<owner>_rdy = 1 this cycle).
- Grant:
  - If only one req_val is high, that requester is granted.
  - If both are high: with p_round_robin = 1, the requester not granted last is chosen; with p_round_robin = 0, requester 0 is chosen.
- reqX_rdy = space & grant==X.
  - reqX_rdy depends combinationally on req*_val and on resp<owner>_rdy.
  - reqX_rdy must not depend on reqX_val's own handshake outcome.
- On accept (val & rdy): the ALU is evaluated on the request fields, and {flags, out} and the owner are written into the buffer. Next state is FULL(X).
- On response accept with no new request: next state is EMPTY.
- Simultaneous response accept and request accept in one cycle: the buffer is overwritten and the state stays FULL(new owner).
- The last-grant pointer updates only on an actual request accept, never on a grant with no space.
- resp_msg is valid only while the matching resp_val is high.
  - The other port's resp_msg carries the same buffer contents; this is don't-care.

## Timing
- Latency is 1 cycle: a request accepted at edge N produces resp val high in the cycle after N.
- Throughput is 1 op/cycle if the consumer holds resp_rdy high.
- resp_val stays high, and resp_msg stays stable, until accepted; this matches val/rdy rules.
- Reset (reset low, asynchronous):
  - State goes to EMPTY and resp0_val = resp1_val = 0.
  - Buffer data clears to 0.
  - The last-grant pointer is set to 1, so requester 0 wins the first tie.
- Reset asserted mid-operation drops any pending response; it is never delivered.
- After reset deasserts, req_rdy may be high in the first cycle.
- Full-buffer backpressure: if FULL(owner) and resp<owner>_rdy = 0, both req_rdy are 0 regardless of the grant.

## Test plan
- Single op: req0 {fn=0, in0=5, in1=7} accepted at edge 1 -> resp0_val=1 in cycle 2, out=12, eq=0, lt=1, ltu=1; resp1_val stays 0.
- Contention, round-robin: both requesters present ops back-to-back every cycle, resp rdy high -> accepted in order 0,1,0,1; each response goes only to its owner. Repeat with p_round_robin=0 -> only requester 0 served while its val is high.
- Backpressure: resp0_rdy=0 for 3 cycles after a req0 SUB {in0=3, in1=5} -> out=32'hfffffffe held stable, req0_rdy=req1_rdy=0 for those cycles. When resp0_rdy rises, a queued req1 is accepted in the same cycle.
- Function corners:
  - SRA {in0=32'h80000000, in1=33} -> out=32'hc0000000.
  - JALR {in0=32'h1001, in1=2} -> out=32'h1002.
  - fn=15 -> out=0.
  - SLT {in0=-1, in1=1} -> lt=1, ltu=0.
- Reset mid-operation: reset low while FULL(1) with resp1_rdy=0 -> resp1_val drops immediately without a clock edge. After release, the first tie is won by requester 0.
